// File: rtl/vga_pkg.sv
// Shared VGA constants and types used by the timing generator and the pixel pipe.
package vga_pkg;

  localparam int unsigned H_VISIBLE    = 640;
  localparam int unsigned V_VISIBLE    = 480;
  localparam int unsigned FB_W         = 320;
  localparam int unsigned FB_H         = 240;
  localparam int unsigned CUR_SIZE_DEF = 8;
  localparam int unsigned ADDR_W       = 17;

  // 12-bit framebuffer word: {R[3:0], G[3:0], B[3:0]}
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  // Per-pixel control bundle carried alongside the memory read
  typedef struct packed {
    logic valid;
    logic hsync;
    logic vsync;
    logic hit;
    logic first;
  } pix_ctl_t;

  // Idle bundle: blank pixel, syncs inactive (high)
  localparam pix_ctl_t CTL_RST = '{valid: 1'b0, hsync: 1'b1, vsync: 1'b1,
                                   hit: 1'b0, first: 1'b0};

endpackage

// File: rtl/vga_pixel_pipe_if.sv
// Framebuffer read port: pipe (master) issues addresses, memory (slave) returns data.
interface vga_pixel_pipe_if;

  logic [vga_pkg::ADDR_W-1:0] mem_addr;
  logic                       mem_rd;
  logic [11:0]                mem_data;

  modport master (output mem_addr, output mem_rd, input mem_data);
  modport slave  (input mem_addr, input mem_rd, output mem_data);

endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with a synchronous reset value.
module vga_delay_line #(
  parameter int unsigned      WIDTH   = 1,
  parameter int unsigned      DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sr [DEPTH];

  // Shift one stage per clock; reset loads every stage with RST_VAL
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_sr[i] <= RST_VAL;
    end else begin
      r_sr[0] <= i_d;
      for (int unsigned i = 1; i < DEPTH; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/vga_pixel_pipe.sv
// Pixel fetch + cursor overlay + sync realignment stage after the VGA timing generator.
module vga_pixel_pipe import vga_pkg::*; #(
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned FB_W     = vga_pkg::FB_W,
  parameter int unsigned CUR_SIZE = CUR_SIZE_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [9:0]              i_h_cnt,
  input  logic [9:0]              i_v_cnt,
  input  logic                    i_valid_in,
  input  logic                    i_hsync_in,
  input  logic                    i_vsync_in,
  vga_pixel_pipe_if.master        mem_if,
  input  logic                    i_cursor_en,
  input  logic [9:0]              i_cursor_x,
  input  logic [9:0]              i_cursor_y,
  output logic [3:0]              o_vga_r,
  output logic [3:0]              o_vga_g,
  output logic [3:0]              o_vga_b,
  output logic                    o_hsync_out,
  output logic                    o_vsync_out,
  output logic                    o_frame_start,
  output logic [15:0]             o_frame_cnt
);

  localparam int unsigned L = MEM_LAT + 1;

  logic [ADDR_W-1:0] w_x, w_y, w_addr;
  logic [10:0]       w_h11, w_v11, w_cx11, w_cy11;
  logic              w_hit;
  pix_ctl_t          w_ctl, w_ctl_dly;
  rgb12_t            w_pix_out;

  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_rd;
  logic [9:0]        r_cx, r_cy;
  logic              r_cur_en;
  rgb12_t            r_rgb;
  logic              r_hsync, r_vsync, r_frame_start;
  logic [15:0]       r_frame_cnt;

  // Upscaled framebuffer address; 320 = 256 + 64 so the default is two shifts and an add
  always_comb begin
    w_x = ADDR_W'(i_h_cnt >> 1);
    w_y = ADDR_W'(i_v_cnt >> 1);
    if (FB_W == 320) w_addr = (w_y << 8) + (w_y << 6) + w_x;
    else             w_addr = w_y * ADDR_W'(FB_W) + w_x;
  end

  // Cursor hit test in 11 bits so cx+CUR_SIZE never wraps back to column 0
  always_comb begin
    w_h11  = {1'b0, i_h_cnt};
    w_v11  = {1'b0, i_v_cnt};
    w_cx11 = {1'b0, r_cx};
    w_cy11 = {1'b0, r_cy};
    w_hit  = r_cur_en && i_valid_in
          && (w_h11 >= w_cx11) && (w_h11 < w_cx11 + 11'(CUR_SIZE))
          && (w_v11 >= w_cy11) && (w_v11 < w_cy11 + 11'(CUR_SIZE));
  end

  // Control bundle for the sampled pixel
  always_comb begin
    w_ctl       = CTL_RST;
    w_ctl.valid = i_valid_in;
    w_ctl.hsync = i_hsync_in;
    w_ctl.vsync = i_vsync_in;
    w_ctl.hit   = w_hit;
    w_ctl.first = i_valid_in && (i_h_cnt == '0) && (i_v_cnt == '0);
  end

  // Stage A: issue the read and latch cursor settings during vertical blanking
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_addr <= '0;
      r_mem_rd   <= 1'b0;
      r_cx       <= '0;
      r_cy       <= '0;
      r_cur_en   <= 1'b0;
    end else begin
      r_mem_addr <= w_addr;
      r_mem_rd   <= i_valid_in;
      if (!i_valid_in && !i_vsync_in) begin
        r_cx     <= i_cursor_x;
        r_cy     <= i_cursor_y;
        r_cur_en <= i_cursor_en;
      end
    end
  end

  assign mem_if.mem_addr = r_mem_addr;
  assign mem_if.mem_rd   = r_mem_rd;

  // Its first stage is stage A; the last stage lines up with mem_data for the same pixel
  vga_delay_line #(
    .WIDTH   ($bits(pix_ctl_t)),
    .DEPTH   (L),
    .RST_VAL (CTL_RST)
  ) u_ctl_dly (
    .clk (clk),
    .rst (rst),
    .i_d (w_ctl),
    .o_q (w_ctl_dly)
  );

  // Blank, inverted (cursor) or plain framebuffer colour
  always_comb begin
    w_pix_out = '0;
    if (w_ctl_dly.valid) begin
      if (w_ctl_dly.hit) w_pix_out = rgb12_t'(~mem_if.mem_data);
      else               w_pix_out = rgb12_t'(mem_if.mem_data);
    end
  end

  // Output register: colour, realigned syncs, frame pulse and counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rgb         <= '0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_frame_start <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      r_rgb         <= w_pix_out;
      r_hsync       <= w_ctl_dly.hsync;
      r_vsync       <= w_ctl_dly.vsync;
      r_frame_start <= w_ctl_dly.first;
      if (w_ctl_dly.first) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign o_vga_r       = r_rgb.r;
  assign o_vga_g       = r_rgb.g;
  assign o_vga_b       = r_rgb.b;
  assign o_hsync_out   = r_hsync;
  assign o_vsync_out   = r_vsync;
  assign o_frame_start = r_frame_start;
  assign o_frame_cnt   = r_frame_cnt;

endmodule
